// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the multicycle MIPS slice:
//   - default datapath widths
//   - mips_mem_if state encodings
//   - multicycle control-unit state codes (used by blocks and benches that
//     need to talk about which control step is driving the memory stage)
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int MIPS_DATA_W = 32;
    localparam int MIPS_ADDR_W = 32;

    // Memory interface state encodings (legacy 2-bit codes)
    localparam logic [1:0] MIF_IDLE  = 2'b00;
    localparam logic [1:0] MIF_BUSY  = 2'b01;
    localparam logic [1:0] MIF_DONE  = 2'b10;
    localparam logic [1:0] MIF_FAULT = 2'b11;

    // Multicycle control-unit states
    typedef enum logic [3:0] {
        CU_FETCH  = 4'd0,
        CU_DECODE = 4'd1,
        CU_MEMADR = 4'd2,
        CU_MEMRD  = 4'd3,
        CU_MEMWB  = 4'd4,
        CU_MEMWR  = 4'd5,
        CU_EXEC   = 4'd6,
        CU_ALUWB  = 4'd7,
        CU_BRANCH = 4'd8,
        CU_JUMP   = 4'd9
    } cu_state_t;

endpackage

// File: rtl/mips_wait_counter.sv
// -----------------------------------------------------------------------------
// mips_wait_counter
// 8-bit wait-cycle counter with clear and enable. tc flags the enabled cycle
// that is the TERMINAL-th one since the last clear, so the owner can act on
// that same clock edge.
// Ports:
//   cclk  in   clock
//   rstb  in   synchronous active-low reset
//   clr   in   synchronous clear (wins over en)
//   en    in   count enable
//   tc    out  terminal count reached in this cycle
// -----------------------------------------------------------------------------
module mips_wait_counter #(
    parameter int unsigned TERMINAL = 255
) (
    input  logic cclk,
    input  logic rstb,
    input  logic clr,
    input  logic en,
    output logic tc
);

    // Count holds the number of enabled cycles already completed, so the
    // TERMINAL-th enabled cycle is the one where count == TERMINAL-1.
    localparam logic [7:0] TC_VALUE = 8'(TERMINAL - 1);

    logic [7:0] count;

    // NOTE: sequential state is written only with non-blocking (<=) assignments
    // so every register samples pre-edge values regardless of block order.
    always_ff @(posedge cclk) begin
        if (!rstb || clr) begin
            count <= 8'd0;
        end else if (en) begin
            count <= count + 8'd1;
        end
    end

    assign tc = en && (count == TC_VALUE);

endmodule

// File: rtl/mips_mem_if.sv
// -----------------------------------------------------------------------------
// mips_mem_if
// Memory stage behind the multicycle MIPS control unit. Turns MemRead/MemWrite
// into a registered req/ack bus transaction, returns the instruction register
// and memory data register, and stalls the control unit until the access
// completes. Misaligned/conflicting requests, bus errors and timeouts land in
// a sticky FAULT state that only reset leaves.
// Ports:
//   cclk, rstb              clock, synchronous active-low reset
//   mem_read, mem_write     access request from the control unit
//   iord                    address select: 1 = alu_out, 0 = pc
//   ir_write                read result goes to instr instead of mdr
//   pc, alu_out, wdata      address sources and store data
//   bus_req/we/addr/wdata   registered bus request fields
//   bus_rdata, bus_ack,
//   bus_err                 bus response (err only meaningful with ack)
//   instr, mdr              instruction / memory data registers
//   stall                   hold the control-unit state register
//   fault                   sticky access fault
// -----------------------------------------------------------------------------
module mips_mem_if
    import mips_pkg::*;
#(
    parameter int DATA_W  = MIPS_DATA_W,
    parameter int ADDR_W  = MIPS_ADDR_W,
    parameter int TIMEOUT = 255
) (
    input  logic              cclk,
    input  logic              rstb,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              iord,
    input  logic              ir_write,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] alu_out,
    input  logic [DATA_W-1:0] wdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    input  logic              bus_err,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] mdr,
    output logic              stall,
    output logic              fault
);

    logic [1:0]        state;
    logic              tgt_ir;
    logic              access;
    logic [ADDR_W-1:0] addr;
    logic              timed_out;

    assign access = mem_read | mem_write;
    assign addr   = iord ? alu_out : pc;

    // Stall drops only in DONE (and in IDLE with nothing requested), which is
    // the single cycle the control unit uses to advance.
    assign stall = ((state == MIF_IDLE) && access)
                 || (state == MIF_BUSY)
                 || (state == MIF_FAULT);

    // Counter runs only while BUSY and restarts from zero on every new access.
    mips_wait_counter #(
        .TERMINAL (TIMEOUT)
    ) u_wait_counter (
        .cclk (cclk),
        .rstb (rstb),
        .clr  (state != MIF_BUSY),
        .en   (state == MIF_BUSY),
        .tc   (timed_out)
    );

    always_ff @(posedge cclk) begin
        if (!rstb) begin
            state     <= MIF_IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            tgt_ir    <= 1'b0;
            instr     <= '0;
            mdr       <= '0;
            fault     <= 1'b0;
        end else begin
            case (state)
                MIF_IDLE: begin
                    if (access) begin
                        // Illegal requests never reach the bus.
                        if ((mem_read && mem_write) || (addr[1:0] != 2'b00)) begin
                            state <= MIF_FAULT;
                            fault <= 1'b1;
                        end else begin
                            bus_addr  <= addr;
                            bus_we    <= mem_write;
                            bus_wdata <= wdata;
                            tgt_ir    <= ir_write && mem_read;
                            bus_req   <= 1'b1;
                            state     <= MIF_BUSY;
                        end
                    end
                end

                MIF_BUSY: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (bus_err) begin
                            state <= MIF_FAULT;
                            fault <= 1'b1;
                        end else begin
                            if (!bus_we) begin
                                if (tgt_ir) begin
                                    instr <= bus_rdata;
                                end else begin
                                    mdr <= bus_rdata;
                                end
                            end
                            state <= MIF_DONE;
                        end
                    end else if (timed_out) begin
                        bus_req <= 1'b0;
                        state   <= MIF_FAULT;
                        fault   <= 1'b1;
                    end
                end

                MIF_DONE: begin
                    state <= MIF_IDLE;
                end

                default: begin
                    // FAULT is absorbing until reset.
                    state <= MIF_FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mem_if.sv
// -----------------------------------------------------------------------------
// tb_mips_mem_if
// Self-checking bench for mips_mem_if. The bench plays the control unit (by
// control-unit state) and a variable-latency memory, and predicts stall
// length, bus fields, fault and the IR/MDR contents from transaction-level
// rules.
// -----------------------------------------------------------------------------
module tb_mips_mem_if;
    import mips_pkg::*;

    localparam int TIMEOUT = 255;

    logic        cclk = 1'b0;
    logic        rstb;
    logic        mem_read, mem_write, iord, ir_write;
    logic [31:0] pc, alu_out, wdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_ack, bus_err;
    logic [31:0] instr, mdr;
    logic        stall, fault;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] exp_instr, exp_mdr;
    logic        exp_fault;

    mips_mem_if #(
        .DATA_W  (32),
        .ADDR_W  (32),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .cclk      (cclk),
        .rstb      (rstb),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .iord      (iord),
        .ir_write  (ir_write),
        .pc        (pc),
        .alu_out   (alu_out),
        .wdata     (wdata),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .bus_err   (bus_err),
        .instr     (instr),
        .mdr       (mdr),
        .stall     (stall),
        .fault     (fault)
    );

    always #5 cclk = ~cclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        iord      = 1'b0;
        ir_write  = 1'b0;
    endtask

    // Called just after a negedge; ends just after a negedge.
    task automatic do_reset(input string tag);
        idle_inputs();
        bus_ack = 1'b0;
        bus_err = 1'b0;
        rstb    = 1'b0;
        @(negedge cclk);
        rstb = 1'b1;
        #1;
        check({tag, ":bus_req"},   bus_req,   0);
        check({tag, ":bus_we"},    bus_we,    0);
        check({tag, ":bus_addr"},  bus_addr,  0);
        check({tag, ":bus_wdata"}, bus_wdata, 0);
        check({tag, ":instr"},     instr,     0);
        check({tag, ":mdr"},       mdr,       0);
        check({tag, ":fault"},     fault,     0);
        check({tag, ":stall"},     stall,     0);
        exp_instr = '0;
        exp_mdr   = '0;
        exp_fault = 1'b0;
        @(negedge cclk);
    endtask

    // One control-unit access. wait_n = number of wait cycles before the ack
    // (ack in BUSY cycle wait_n+1); wait_n < 0 means the memory never answers.
    task automatic cu_access(input string tag, input cu_state_t st,
                             input logic [31:0] pcv, input logic [31:0] aluv,
                             input logic [31:0] wd, input logic [31:0] rdv,
                             input int wait_n, input logic err);
        logic        rd, wr, io, irw;
        logic [31:0] addr;
        bit          acc, bad, tmo, ended, done_seen;
        int          stall_cnt, req_cnt, exp_stall, exp_req;
        logic [31:0] first_addr, first_wdata, done_instr, done_mdr;
        logic        first_we;

        rd  = (st == CU_FETCH) || (st == CU_MEMRD) || (st == CU_MEMADR);
        wr  = (st == CU_MEMWR) || (st == CU_MEMADR);   // MEMADR used as illegal both-set
        io  = (st != CU_FETCH);
        irw = (st == CU_FETCH);

        addr = io ? aluv : pcv;
        acc  = rd || wr;
        bad  = acc && ((rd && wr) || (addr[1:0] != 2'b00));
        tmo  = acc && !bad && (wait_n < 0 || wait_n >= TIMEOUT);

        mem_read  = rd;
        mem_write = wr;
        iord      = io;
        ir_write  = irw;
        pc        = pcv;
        alu_out   = aluv;
        wdata     = wd;

        stall_cnt = 0;  req_cnt = 0;  ended = 0;  done_seen = 0;
        first_addr = '0; first_wdata = '0; first_we = 1'b0;
        done_instr = '0; done_mdr = '0;

        for (int c = 0; c < TIMEOUT + 50 && !ended; c++) begin
            #1;
            if (fault) begin
                ended = 1;
            end else begin
                if (bus_req) begin
                    if (req_cnt == 0) begin
                        first_addr  = bus_addr;
                        first_we    = bus_we;
                        first_wdata = bus_wdata;
                    end
                    bus_ack   = !tmo && (req_cnt == wait_n);
                    bus_err   = err;
                    bus_rdata = rdv;
                    req_cnt++;
                end
                if (stall) begin
                    stall_cnt++;
                end else begin
                    done_seen  = 1;
                    ended      = 1;
                    done_instr = instr;
                    done_mdr   = mdr;
                end
            end
            @(negedge cclk);
            bus_ack = 1'b0;
            bus_err = 1'b0;
        end
        idle_inputs();

        // Transaction-level expectations
        if (!acc) begin
            exp_stall = 0;  exp_req = 0;
        end else if (bad) begin
            exp_stall = 1;  exp_req = 0;  exp_fault = 1'b1;
        end else if (tmo) begin
            exp_stall = TIMEOUT + 1;  exp_req = TIMEOUT;  exp_fault = 1'b1;
        end else begin
            exp_stall = wait_n + 2;  exp_req = wait_n + 1;
            if (err) begin
                exp_fault = 1'b1;
            end else if (rd) begin
                if (irw) exp_instr = rdv;
                else     exp_mdr   = rdv;
            end
        end

        check({tag, ":ended"},   ended,     1);
        check({tag, ":stall_n"}, stall_cnt, exp_stall);
        check({tag, ":req_n"},   req_cnt,   exp_req);
        if (exp_req > 0) begin
            check({tag, ":addr"},  first_addr,  addr);
            check({tag, ":we"},    first_we,    wr);
            check({tag, ":wdata"}, first_wdata, wd);
        end
        if (!exp_fault) begin
            check({tag, ":done"},       done_seen,  1);
            check({tag, ":done_instr"}, done_instr, exp_instr);
            check({tag, ":done_mdr"},   done_mdr,   exp_mdr);
        end
        #1;
        check({tag, ":fault"}, fault, exp_fault);
        check({tag, ":instr"}, instr, exp_instr);
        check({tag, ":mdr"},   mdr,   exp_mdr);
        if (exp_fault) begin
            check({tag, ":fault_stall"}, stall,   1);
            check({tag, ":fault_req"},   bus_req, 0);
        end
        @(negedge cclk);
    endtask

    // An ack with no request outstanding must not disturb anything.
    task automatic stray_ack(input string tag, input logic [31:0] rdv);
        bus_ack   = 1'b1;
        bus_err   = 1'b0;
        bus_rdata = rdv;
        @(negedge cclk);
        bus_ack = 1'b0;
        #1;
        check({tag, ":instr"},   instr,   exp_instr);
        check({tag, ":mdr"},     mdr,     exp_mdr);
        check({tag, ":fault"},   fault,   exp_fault);
        check({tag, ":bus_req"}, bus_req, 0);
        @(negedge cclk);
    endtask

    initial begin
        cu_state_t st;
        logic [31:0] a;
        int k;

        idle_inputs();
        pc = '0; alu_out = '0; wdata = '0;
        bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
        rstb = 1'b0;
        exp_instr = '0; exp_mdr = '0; exp_fault = 1'b0;
        @(negedge cclk);
        do_reset("reset");

        stray_ack("ack_idle", 32'hA5A5_5A5A);

        cu_access("fetch0", CU_FETCH, 32'h0000_0040, 32'h0, 32'h0, 32'h8C22_0004, 0, 1'b0);
        cu_access("load3",  CU_MEMRD, 32'h0000_0044, 32'h0000_1008, 32'h0, 32'hDEAD_BEEF, 3, 1'b0);
        cu_access("store1", CU_MEMWR, 32'h0000_0048, 32'h0000_200C, 32'h1234_5678, 32'h0BAD_0BAD, 1, 1'b0);
        cu_access("buserr", CU_MEMRD, 32'h0000_004C, 32'h0000_1010, 32'h0, 32'h1111_2222, 0, 1'b1);
        do_reset("rst_err");

        cu_access("misalign", CU_MEMRD, 32'h0000_0050, 32'h0000_1002, 32'h0, 32'h0, 0, 1'b0);
        do_reset("rst_mis");
        cu_access("rd_wr", CU_MEMADR, 32'h0000_0054, 32'h0000_1000, 32'h0, 32'h0, 0, 1'b0);
        do_reset("rst_rdwr");

        cu_access("prefill", CU_MEMRD, 32'h0, 32'h0000_3000, 32'h0, 32'h7777_8888, 0, 1'b0);
        cu_access("timeout", CU_MEMRD, 32'h0, 32'h0000_3004, 32'h0, 32'h0, -1, 1'b0);
        stray_ack("late_ack", 32'h9999_AAAA);
        do_reset("rst_tmo");

        // Reset during the second wait cycle of a load
        mem_read = 1'b1; iord = 1'b1; alu_out = 32'h0000_4000;
        @(negedge cclk);   // BUSY, wait cycle 1
        @(negedge cclk);   // BUSY, wait cycle 2
        #1;
        check("midrst:busy_req", bus_req, 1);
        do_reset("midrst");
        stray_ack("midrst_ack", 32'hCAFE_F00D);
        cu_access("fetch_after", CU_FETCH, 32'h0000_0100, 32'h0, 32'h0, 32'h2001_0005, 0, 1'b0);

        // Randomized control-unit traffic
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 9);
            if (k < 4)      st = CU_FETCH;
            else if (k < 7) st = CU_MEMRD;
            else if (k < 9) st = CU_MEMWR;
            else            st = ($urandom_range(0, 1) == 0) ? CU_MEMADR : CU_EXEC;
            a = $urandom();
            if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            cu_access($sformatf("rnd%0d", i), st, {a[31:2], 2'b00}, a, $urandom(), $urandom(),
                      $urandom_range(0, 4), ($urandom_range(0, 9) == 0));
            if (exp_fault) do_reset($sformatf("rnd_rst%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_mem_if.md
Name: mips_mem_if

Overview:
Memory interface stage that sits directly downstream of the multicycle MIPS control unit.
- Consumes MemRead, MemWrite, IorD and IrWrite.
- Runs a req/ack transaction on a variable-latency memory bus.
- Returns the instruction register contents (the control unit's I input) and the memory data register (MDR).
- Asserts stall so the control-unit state register holds until the access completes.

Parameters:
- DATA_W, 32, data/instruction width
- ADDR_W, 32, byte address width
- TIMEOUT, 255, maximum BUSY cycles without bus_ack before fault (8-bit counter)

Ports:
- cclk  in  1  clock
- rstb  in  1  synchronous active-low reset
- mem_read  in  1  MemRead from control unit
- mem_write  in  1  MemWrite from control unit
- iord  in  1  address select: 1 = alu_out, 0 = pc
- ir_write  in  1  read targets IR instead of MDR
- pc  in  ADDR_W  program counter
- alu_out  in  ADDR_W  ALUOut register (load/store address)
- wdata  in  DATA_W  B register (store data)
- bus_req  out  1  transaction request, registered
- bus_we  out  1  1 = write, registered
- bus_addr  out  ADDR_W  registered address
- bus_wdata  out  DATA_W  registered write data
- bus_rdata  in  DATA_W  read data, valid with bus_ack
- bus_ack  in  1  transaction complete
- bus_err  in  1  error, sampled only with bus_ack
- instr  out  DATA_W  instruction register
- mdr  out  DATA_W  memory data register
- stall  out  1  hold control-unit state
- fault  out  1  sticky access fault

Behaviour:
- Reset: rstb low at a cclk edge clears the following; the state goes to IDLE.
  - bus_req, bus_we, bus_addr, bus_wdata
  - instr, mdr
  - fault
  - timeout counter
- A reset mid-transaction drops bus_req at that edge. A late bus_ack afterwards is ignored.
- access = mem_read | mem_write. addr = iord ? alu_out : pc.
- stall is combinational: (IDLE & access) | BUSY | FAULT. It is 0 in DONE.
- IDLE, on access:
  - mem_read & mem_write both 1 -> FAULT.
  - addr[1:0] != 0 -> FAULT; no bus transaction.
  - Otherwise latch bus_addr = addr, bus_we = mem_write, bus_wdata = wdata, tgt_ir = ir_write & mem_read. Set bus_req = 1 and go to BUSY.
- BUSY:
  - Hold bus_req and the latched fields stable; increment the counter each cycle.
  - bus_ack & ~bus_err -> drop bus_req. On a read, capture bus_rdata into instr if tgt_ir, else into mdr. Go to DONE.
  - bus_ack & bus_err -> drop bus_req and go to FAULT; instr and mdr are unchanged.
  - Counter reaches TIMEOUT with no ack -> drop bus_req and go to FAULT.
- DONE:
  - One cycle with stall = 0, so the control unit advances. Always go to IDLE.
  - Request inputs seen during DONE are ignored.
- FAULT: absorbing. fault = 1 and stall = 1 until reset.
- Latency: a zero-wait memory (ack in the first BUSY cycle) gives IDLE, BUSY, DONE: 2 stalled cycles, and data visible in the DONE cycle. Each extra wait cycle adds one stall cycle.
- instr and mdr change only on a successful read ack; they are otherwise held.
- An ack in IDLE or DONE is ignored.

Decomposition:
- Shared package mips_pkg holds:
  - state encodings MIF_IDLE = 2'b00, MIF_BUSY = 2'b01, MIF_DONE = 2'b10, MIF_FAULT = 2'b11
  - the DATA_W/ADDR_W defaults
  - the control-unit state codes, reused by the bench
- One sub-module, mips_wait_counter:
  - an 8-bit counter with clear/enable
  - terminal-count flag compared against TIMEOUT

Test Plan:
- Fetch, zero-wait: pc = 0x00000040, mem_read = 1, ir_write = 1, iord = 0, ack next cycle with rdata = 0x8C220004 -> bus_req high for 1 cycle, addr = 0x40, we = 0, stall high 2 cycles, instr = 0x8C220004 in the DONE cycle, mdr unchanged.
- Load with 3 wait states: alu_out = 0x00001008, iord = 1, mem_read = 1, ack on the 4th BUSY cycle with rdata = 0xDEADBEEF -> stall 5 cycles, mdr = 0xDEADBEEF, instr unchanged.
- Store: mem_write = 1, alu_out = 0x0000200C, wdata = 0x12345678, ack after 1 wait -> bus_we = 1, bus_wdata = 0x12345678, instr and mdr unchanged, stall 3 cycles.
- Faults: misaligned addr 0x00001002 -> bus_req never asserts, fault = 1 next cycle, stall stays 1. Both mem_read and mem_write = 1 -> same response. bus_err with ack -> fault = 1, mdr unchanged.
- Timeout: no ack -> bus_req drops and fault = 1 after 255 BUSY cycles. A later ack has no effect.
- Reset mid-BUSY: rstb = 0 for 1 cycle during the 2nd wait cycle -> all outputs 0 and state IDLE. A subsequent ack is ignored. A new fetch then completes normally.
